wb_arbiter: RTL and testbench
=============================

// Module: wb_arbiter
// PURPOSE
//  Writeback stage directly upstream of the 32x32 register file; sole driver of its write port.
//  Merges single-cycle ALU results with long-latency (load/mul/div) results into one registered write/cycle.
//  Keeps a pending-write scoreboard so decode can stall on RAW hazards against long-latency destinations.
// PARAMETERS
//  DEPTH        4   long-latency result FIFO entries (power of 2, >=2)
//  STARVE_LIMIT 3   consecutive cycles a non-empty FIFO head may lose to the ALU before it is forced out
// PORTS
//  clk        in   1   clock; all state updates on posedge
//  nrst       in   1   synchronous active-low reset
//  alu_valid  in   1   ALU result present; held until accepted (alu_valid && !alu_stall)
//  alu_addr   in   5   ALU destination register
//  alu_data   in   32  ALU result
//  alu_stall  out  1   combinational; 1 = ALU result not accepted this cycle
//  llu_valid  in   1   long-latency result present
//  llu_ready  out  1   combinational; = !fifo_full; push on llu_valid && llu_ready
//  llu_addr   in   5   long-latency destination register
//  llu_data   in   32  long-latency result
//  iss_valid  in   1   decode issued a long-latency op this cycle
//  iss_addr   in   5   its destination; marks scoreboard busy
//  chk_addrA  in   5   decode source A to check
//  chk_addrB  in   5   decode source B to check
//  busyA      out  1   combinational; = busy[chk_addrA]
//  busyB      out  1   combinational; = busy[chk_addrB]
//  wr_en      out  1   registered; regfile write enable
//  wr_addr    out  5   registered; regfile write address
//  wr_data    out  32  registered; regfile write data
// BEHAVIOUR
//  Reset (nrst=0 at posedge): wr_en=0, wr_addr=0, wr_data=0, FIFO emptied, busy=0, starve_cnt=0; inputs ignored that cycle.
//  Latency: accepted ALU result -> wr_* next cycle (1 clk). FIFO push -> earliest wr_* 2 clks later.
//  Arbitration per cycle: force = fifo_nonempty && starve_cnt==STARVE_LIMIT.
//   force: pop FIFO head to wr_*; alu_stall=1 if alu_valid. starve_cnt<=0.
//   else alu_valid: ALU to wr_*; alu_stall=0; starve_cnt<=starve_cnt+1 if FIFO non-empty, else 0.
//   else FIFO non-empty: pop head to wr_*; starve_cnt<=0.  else wr_en<=0, wr_addr/wr_data hold.
//  Address 0: ALU or FIFO result with addr 0 is consumed (accepted/popped) but wr_en<=0. r0 never busy.
//  FIFO: push and pop same cycle allowed when not full; llu_ready low while full (no push-through).
//  Scoreboard busy[31:0]: set at posedge when iss_valid && iss_addr!=0; cleared when FIFO head with that addr is popped.
//   Same-cycle set and clear on one addr: set wins.
//  iss_valid to an already-busy addr is a protocol violation (decode stalls); flagged by assertion, no state change.
//  ALU write to a busy addr is legal; busy unaffected.
//  busyA/busyB reflect register state only; a pop in the current cycle clears busy from the next cycle.
// CONFIGURATION
//  WB_FWD_EN defined: adds outputs fwd_hitA, fwd_hitB (1) and fwd_dataA, fwd_dataB (32).
//   fwd_hitX = wr_en && wr_addr==chk_addrX && chk_addrX!=0; fwd_dataX = wr_data.
//   Covers the write-then-read-same-cycle window of the regfile.
//  WB_FWD_EN undefined: those ports absent; decode waits one extra cycle on that window.
// STRUCTURE
//  Shared package wb_pkg: REG_ADDR_W=5, DATA_W=32, NUM_REGS=32, typedef wb_entry_t {addr, data}.
//  Sub-module wb_fifo: DEPTH x wb_entry_t synchronous FIFO.
//   Ports: push, pop, head, full, empty; count resets to 0 on nrst.
//  Top holds arbitration, starve counter, scoreboard and output registers.
// TESTING
//  1 Reset: nrst=0 for 2 clks with all valids=1 -> wr_en=0, busy=0, llu_ready=1 after release.
//  2 ALU only: alu_valid, addr=5, data=0x1234 -> next clk wr_en=1, wr_addr=5, wr_data=0x1234.
//    addr=0 -> wr_en=0.
//  3 Scoreboard: iss_valid addr=8 -> busyA=1 (chk_addrA=8) next clk.
//    llu push addr=8 data=0xBEEF, no ALU -> wr 8/0xBEEF 2 clks after push; busyA=0 the clk after.
//  4 Starvation: FIFO holds 1 entry, alu_valid held high -> ALU wins 3 clks.
//    4th clk alu_stall=1 and FIFO entry written; ALU data written the clk after.
//  5 Full: 4 pushes with alu_valid constant -> llu_ready=0.
//    5th llu_valid held until a pop; no entry lost, order preserved.
//  6 Mid-op reset with 3 FIFO entries and busy={3,4,9} -> all flushed, busy=0, no stray write after.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage: register-file geometry and the
// long-latency result entry carried through the writeback FIFO.
package wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of long-latency writeback entries. Head is presented
// combinationally; push into a full FIFO and pop from an empty one are ignored.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      nrst,
  input  logic      push,
  input  logic      pop,
  input  wb_entry_t din,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  wb_entry_t       r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [AW:0]     r_count;
  logic            w_do_push;
  logic            w_do_pop;

  assign full      = (r_count == (AW+1)'(DEPTH));
  assign empty     = (r_count == '0);
  assign head      = r_mem[r_rptr];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-2 depth).
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; data only, so no reset needed.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= din;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU and long-latency results into one registered
// register-file write per cycle, bounds FIFO starvation, and tracks pending
// long-latency destinations for decode RAW checks.
// Optional feature macro WB_FWD_EN adds same-cycle forwarding outputs.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0]     alu_data,
  output logic                  alu_stall,
  input  logic                  llu_valid,
  output logic                  llu_ready,
  input  logic [REG_ADDR_W-1:0] llu_addr,
  input  logic [DATA_W-1:0]     llu_data,
  input  logic                  iss_valid,
  input  logic [REG_ADDR_W-1:0] iss_addr,
  input  logic [REG_ADDR_W-1:0] chk_addrA,
  input  logic [REG_ADDR_W-1:0] chk_addrB,
  output logic                  busyA,
  output logic                  busyB,
  output logic                  wr_en,
  output logic [REG_ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0]     wr_data
`ifdef WB_FWD_EN
  ,
  output logic                  fwd_hitA,
  output logic                  fwd_hitB,
  output logic [DATA_W-1:0]     fwd_dataA,
  output logic [DATA_W-1:0]     fwd_dataB
`endif
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  wb_entry_t             w_head;
  wb_entry_t             w_llu_entry;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_ne;
  logic                  w_force;
  logic                  w_pop;
  logic                  w_push;
  logic [CW-1:0]         r_starve;
  logic [NUM_REGS-1:0]   r_busy;
  logic [NUM_REGS-1:0]   w_busy_nxt;
  logic                  r_wr_en;
  logic [REG_ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0]     r_wr_data;

  assign w_llu_entry = '{addr: llu_addr, data: llu_data};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .nrst  (nrst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_llu_entry),
    .head  (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  // Arbitration decision: the FIFO head is forced out once it has lost too often.
  always_comb begin
    w_ne    = !w_empty;
    w_force = w_ne && (r_starve == CW'(STARVE_LIMIT));
    w_pop   = w_force || (!alu_valid && w_ne);
    w_push  = llu_valid && !w_full;
  end

  assign alu_stall = alu_valid && w_force;
  assign llu_ready = !w_full;

  // Registered write port and starvation counter; address 0 is consumed silently.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_starve  <= '0;
    end else if (w_pop) begin
      r_wr_en   <= (w_head.addr != '0);
      r_wr_addr <= w_head.addr;
      r_wr_data <= w_head.data;
      r_starve  <= '0;
    end else if (alu_valid) begin
      r_wr_en   <= (alu_addr != '0);
      r_wr_addr <= alu_addr;
      r_wr_data <= alu_data;
      r_starve  <= w_ne ? r_starve + 1'b1 : '0;
    end else begin
      r_wr_en   <= 1'b0;
      r_starve  <= '0;
    end
  end

  // Scoreboard next state: clear on head pop, then set on issue so set wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_pop) w_busy_nxt[w_head.addr] = 1'b0;
    if (iss_valid && (iss_addr != '0)) w_busy_nxt[iss_addr] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (!nrst) r_busy <= '0;
    else       r_busy <= w_busy_nxt;
  end

  // Decode must never issue to a destination that is still pending.
  always_ff @(posedge clk) begin
    if (nrst && iss_valid && (iss_addr != '0)) assert (!r_busy[iss_addr]);
  end

  assign busyA   = r_busy[chk_addrA];
  assign busyB   = r_busy[chk_addrB];
  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;

`ifdef WB_FWD_EN
  assign fwd_hitA  = r_wr_en && (r_wr_addr == chk_addrA) && (chk_addrA != '0);
  assign fwd_hitB  = r_wr_en && (r_wr_addr == chk_addrB) && (chk_addrB != '0);
  assign fwd_dataA = r_wr_data;
  assign fwd_dataB = r_wr_data;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed vectors with literal expectations plus a
// queue-based reference model compared on every falling edge.
module tb_wb_arbiter;
  import wb_pkg::*;

  localparam int M_DEPTH = 4;
  localparam int M_LIMIT = 3;

  logic        clk = 1'b0;
  logic        nrst;
  logic        alu_valid, llu_valid, iss_valid;
  logic [4:0]  alu_addr, llu_addr, iss_addr, chk_addrA, chk_addrB;
  logic [31:0] alu_data, llu_data;
  logic        alu_stall, llu_ready, busyA, busyB, wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
`ifdef WB_FWD_EN
  logic        fwd_hitA, fwd_hitB;
  logic [31:0] fwd_dataA, fwd_dataB;
`endif

  int total = 0;
  int bad   = 0;

  wb_arbiter #(.DEPTH(4), .STARVE_LIMIT(3)) dut (
    .clk(clk), .nrst(nrst),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_stall(alu_stall),
    .llu_valid(llu_valid), .llu_ready(llu_ready), .llu_addr(llu_addr), .llu_data(llu_data),
    .iss_valid(iss_valid), .iss_addr(iss_addr),
    .chk_addrA(chk_addrA), .chk_addrB(chk_addrB), .busyA(busyA), .busyB(busyB),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
`ifdef WB_FWD_EN
    , .fwd_hitA(fwd_hitA), .fwd_hitB(fwd_hitB), .fwd_dataA(fwd_dataA), .fwd_dataB(fwd_dataB)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model state: what the register file write port and scoreboard must show.
  wb_entry_t   m_q[$];
  logic [31:0] m_busy  = '0;
  int          m_starve = 0;
  logic        m_en    = 1'b0;
  logic [4:0]  m_addr  = '0;
  logic [31:0] m_data  = '0;
  bit          m_live  = 1'b0;

  always @(negedge clk) begin
    bit        frc, nonempty, can_push;
    wb_entry_t e;
    nonempty = (m_q.size() > 0);
    frc      = nonempty && (m_starve == M_LIMIT);
    if (m_live) begin
      chk("m_wr_en", wr_en, m_en);
      if (m_en) begin
        chk("m_wr_addr", wr_addr, m_addr);
        chk("m_wr_data", wr_data, m_data);
      end
      chk("m_alu_stall", alu_stall, alu_valid && frc);
      chk("m_llu_ready", llu_ready, m_q.size() < M_DEPTH);
      chk("m_busyA", busyA, m_busy[chk_addrA]);
      chk("m_busyB", busyB, m_busy[chk_addrB]);
`ifdef WB_FWD_EN
      chk("m_fwd_hitA", fwd_hitA, m_en && m_addr == chk_addrA && chk_addrA != 0);
      chk("m_fwd_hitB", fwd_hitB, m_en && m_addr == chk_addrB && chk_addrB != 0);
      if (m_en) chk("m_fwd_dataA", fwd_dataA, m_data);
`endif
    end
    // Advance the model by the edge that is about to happen.
    if (!nrst) begin
      m_q.delete();
      m_busy = '0; m_starve = 0; m_en = 1'b0; m_addr = '0; m_data = '0;
    end else begin
      can_push = llu_valid && (m_q.size() < M_DEPTH);
      if (frc || (!alu_valid && nonempty)) begin
        e = m_q.pop_front();
        m_en = (e.addr != 0); m_addr = e.addr; m_data = e.data;
        m_busy[e.addr] = 1'b0;
        m_starve = 0;
      end else if (alu_valid) begin
        m_en = (alu_addr != 0); m_addr = alu_addr; m_data = alu_data;
        m_starve = nonempty ? m_starve + 1 : 0;
      end else begin
        m_en = 1'b0;
        m_starve = 0;
      end
      if (can_push) m_q.push_back('{addr: llu_addr, data: llu_data});
      if (iss_valid && iss_addr != 0) m_busy[iss_addr] = 1'b1;
    end
    m_live = 1'b1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wr(input string nm, input logic [4:0] a, input logic [31:0] d);
    chk({nm, "_en"}, wr_en, 1'b1);
    chk({nm, "_addr"}, wr_addr, a);
    chk({nm, "_data"}, wr_data, d);
  endtask

  initial begin
    // Reset with every valid asserted
    nrst = 1'b0;
    alu_valid = 1'b1; alu_addr = 5'd6; alu_data = 32'h6666;
    llu_valid = 1'b1; llu_addr = 5'd7; llu_data = 32'h7777;
    iss_valid = 1'b1; iss_addr = 5'd7;
    chk_addrA = 5'd7; chk_addrB = 5'd6;
    step(); step();
    nrst = 1'b1; alu_valid = 1'b0; llu_valid = 1'b0; iss_valid = 1'b0;
    #1;
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_wr_addr", wr_addr, 5'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_busyA", busyA, 1'b0);
    chk("rst_llu_ready", llu_ready, 1'b1);

    // ALU only, then ALU to r0
    alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'h1234;
    #1 chk("alu_stall0", alu_stall, 1'b0);
    step();
    chk_wr("alu5", 5'd5, 32'h1234);
    alu_addr = 5'd0; alu_data = 32'h99;
    step();
    chk("alu_r0_wr_en", wr_en, 1'b0);
    alu_valid = 1'b0;
    step();

    // Scoreboard set by issue, cleared by the long-latency writeback
    iss_valid = 1'b1; iss_addr = 5'd8;
    step();
    iss_valid = 1'b0; chk_addrA = 5'd8;
    #1 chk("sb_busy_set", busyA, 1'b1);
    llu_valid = 1'b1; llu_addr = 5'd8; llu_data = 32'hBEEF;
    step();
    llu_valid = 1'b0;
    #1;
    chk("sb_no_wr_yet", wr_en, 1'b0);
    chk("sb_busy_held", busyA, 1'b1);
    step();
    chk_wr("sb_llu8", 5'd8, 32'hBEEF);
    chk("sb_busy_clr", busyA, 1'b0);

    // Starvation: ALU wins three times against a waiting head, then is stalled
    alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 32'h100;
    llu_valid = 1'b1; llu_addr = 5'd10; llu_data = 32'hAAAA;
    step();
    llu_valid = 1'b0;
    chk_wr("st_alu1", 5'd1, 32'h100);
    for (int k = 2; k <= 4; k++) begin
      alu_addr = 5'(k); alu_data = 32'(k * 256);
      #1 chk("st_no_stall", alu_stall, 1'b0);
      step();
      chk_wr("st_alu", 5'(k), 32'(k * 256));
    end
    alu_addr = 5'd5; alu_data = 32'h500;
    #1 chk("st_stall", alu_stall, 1'b1);
    step();
    chk_wr("st_forced", 5'd10, 32'hAAAA);
    chk("st_unstall", alu_stall, 1'b0);
    step();
    chk_wr("st_alu5", 5'd5, 32'h500);

    // Full FIFO with the ALU held constant
    alu_addr = 5'd20; alu_data = 32'h2020;
    for (int i = 0; i < 4; i++) begin
      llu_valid = 1'b1; llu_addr = 5'(11 + i); llu_data = 32'hC00 + 32'(i);
      step();
    end
    llu_addr = 5'd15; llu_data = 32'hC04;
    #1;
    chk("full_ready", llu_ready, 1'b0);
    chk("full_stall", alu_stall, 1'b1);
    step();
    chk_wr("full_pop11", 5'd11, 32'hC00);
    chk("full_ready_back", llu_ready, 1'b1);
    step();
    chk_wr("full_alu", 5'd20, 32'h2020);
    llu_valid = 1'b0; alu_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_wr("full_order", 5'(12 + i), 32'hC01 + 32'(i));
    end
    step();
    chk("full_drained", wr_en, 1'b0);

    // Mid-operation reset with pending entries and busy registers
    iss_valid = 1'b1; iss_addr = 5'd3; step();
    iss_addr = 5'd4; step();
    iss_addr = 5'd9; step();
    iss_valid = 1'b0;
    alu_valid = 1'b1; alu_addr = 5'd21; alu_data = 32'h2121;
    llu_valid = 1'b1; llu_addr = 5'd3; llu_data = 32'h3333; step();
    llu_addr = 5'd4; llu_data = 32'h4444; step();
    llu_addr = 5'd9; llu_data = 32'h9999; step();
    chk_addrA = 5'd3; chk_addrB = 5'd4;
    #1;
    chk("mr_busy3", busyA, 1'b1);
    chk("mr_busy4", busyB, 1'b1);
    nrst = 1'b0; llu_addr = 5'd22;
    step();
    nrst = 1'b1; alu_valid = 1'b0; llu_valid = 1'b0;
    #1;
    chk("mr_busy3_clr", busyA, 1'b0);
    chk("mr_busy4_clr", busyB, 1'b0);
    chk("mr_ready", llu_ready, 1'b1);
    chk("mr_wr_en", wr_en, 1'b0);
    chk_addrA = 5'd9;
    #1 chk("mr_busy9_clr", busyA, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mr_no_stray", wr_en, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
